// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock,
// through a single full-subtractor cell and a registered borrow. A start/busy/done
// handshake frames each operation. Results are held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current operand LSBs and the stored borrow.
  assign x        = a_sr[0];
  assign y        = b_sr[0];
  assign d        = x ^ y ^ br;
  assign br_next  = (~x & y) | (~(x ^ y) & br);
  assign res_next = {d, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, serial shift datapath and result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CNT_W'(1);
          // The final bit is folded in directly so the visible result lands on
          // the same edge the FSM enters DONE.
          if (last_bit) begin
            diff <= res_next;
            bout <= br_next;
            zero <= (res_next == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are queued
// when an operation is launched and matched in order against every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  res_t exp_q[$];
  res_t obs_q[$];
  res_t last_exp;
  int   rd_idx;
  int   n_checks;
  int   n_errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle in which done is seen high, with the result outputs.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_q.push_back('{diff: diff, bout: bout, zero: zero});
    end
  end

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    res_t r;
    r.diff = W'(ma - mb);
    r.bout = (ma < mb);
    r.zero = (r.diff == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Match all recorded done pulses against the queued expectations.
  task automatic drain(input string tag);
    res_t o;
    res_t e;
    while (rd_idx < obs_q.size()) begin
      o = obs_q[rd_idx];
      rd_idx++;
      if (exp_q.size() == 0) begin
        check({tag, " unexpected done"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, " diff"}, 32'(o.diff), 32'(e.diff));
        check({tag, " bout"}, 32'(o.bout), 32'(e.bout));
        check({tag, " zero"}, 32'(o.zero), 32'(e.zero));
        last_exp = e;
      end
    end
    check({tag, " results still pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Launch one operation and follow it to completion; optionally pulse start
  // (with different operands) at cycles 3 and 8 of the running operation.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input bit pulses);
    int busy_cyc;
    int done_at;
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    exp_q.push_back(model(va, vb));
    busy_cyc = 0;
    done_at  = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1 && done_at == 0) done_at = cyc;
      if (cyc == 5) begin
        check({tag, " held diff"}, 32'(diff), 32'(last_exp.diff));
        check({tag, " held bout"}, 32'(bout), 32'(last_exp.bout));
        check({tag, " held zero"}, 32'(zero), 32'(last_exp.zero));
      end
      if (pulses && (cyc == 3 || cyc == 8)) begin
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) break;
    end
    check({tag, " busy cycles"}, 32'(busy_cyc), 32'd9);
    check({tag, " done cycle"}, 32'(done_at), 32'd9);
    drain(tag);
  endtask

  initial begin
    res_t zero_res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_errors = 0;
    rd_idx   = 0;
    zero_res = '{diff: '0, bout: 1'b0, zero: 1'b0};
    last_exp = zero_res;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations, including equality and wrap-around.
    run_op("5-3", 8'h05, 8'h03, 1'b0);
    run_op("3-5", 8'h03, 8'h05, 1'b0);
    run_op("A5-A5", 8'hA5, 8'hA5, 1'b0);
    run_op("00-FF", 8'h00, 8'hFF, 1'b0);

    // Start pulses during SHIFT are ignored; only one done is produced.
    run_op("80-01 ignore start", 8'h80, 8'h01, 1'b1);
    repeat (15) @(negedge clk);
    drain("after ignored starts");

    // Reset during SHIFT bit 4 aborts the operation.
    @(negedge clk);
    a     = 8'h55;
    b     = 8'h0F;
    start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    last_exp = zero_res;
    repeat (15) @(negedge clk);
    drain("after abort");
    run_op("FF-01 after abort", 8'hFF, 8'h01, 1'b0);

    // start held high: one acceptance every WIDTH+2 cycles.
    @(negedge clk);
    ra    = W'($urandom);
    rb    = W'($urandom);
    a     = ra;
    b     = rb;
    start = 1'b1;
    exp_q.push_back(model(ra, rb));
    for (int k = 0; k < 6; k++) begin
      repeat (10) @(negedge clk);
      if (k < 5) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if (k == 2) rb = ra;
        a  = ra;
        b  = rb;
        exp_q.push_back(model(ra, rb));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("back-to-back idle busy", 32'(busy), 32'd0);
    drain("back-to-back");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
